// File: rtl/reg_40xx_2r_1w_sync.sv
// Register file: 40 entries of WIDTH bits, one write port and two read ports.
// Reads are registered (one-cycle latency) with write-first bypass.
// Out-of-range accesses return zero and raise a sticky addr_err flag.
module reg_40xx_2r_1w_sync #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [5:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd0_en,
    input  logic [5:0]       rd0_addr,
    input  logic             rd1_en,
    input  logic [5:0]       rd1_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic             rd0_valid,
    output logic [WIDTH-1:0] rd1_data,
    output logic             rd1_valid,
    output logic             addr_err
);

    localparam logic [5:0] DEPTH = 6'd40;

    logic [WIDTH-1:0] mem_r [0:39];

    logic [WIDTH-1:0] rd0_data_r;
    logic [WIDTH-1:0] rd1_data_r;
    logic             rd0_valid_r;
    logic             rd1_valid_r;
    logic             addr_err_r;

    logic             wr_in_range_s;
    logic             rd0_in_range_s;
    logic             rd1_in_range_s;
    logic [5:0]       rd0_idx_s;
    logic [5:0]       rd1_idx_s;
    logic [WIDTH-1:0] rd0_word_s;
    logic [WIDTH-1:0] rd1_word_s;
    logic             err_set_s;

    // Resolve the word a read port returns: zero when out of range, the
    // incoming write data when the same entry is written this edge, else storage.
    function automatic logic [WIDTH-1:0] select_word(
        input logic             in_range,
        input logic             bypass_hit,
        input logic [WIDTH-1:0] bypass_data,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] word;
        if (!in_range) begin
            word = {WIDTH{1'b0}};
        end else if (bypass_hit) begin
            word = bypass_data;
        end else begin
            word = stored;
        end
        return word;
    endfunction

    // Address decode, bypass selection and error detection for the current edge.
    always_comb begin
        wr_in_range_s  = (wr_addr  < DEPTH);
        rd0_in_range_s = (rd0_addr < DEPTH);
        rd1_in_range_s = (rd1_addr < DEPTH);
        // Out-of-range indices are steered to entry 0 so the array is never
        // indexed past its end; the result is masked to zero by select_word.
        rd0_idx_s = rd0_in_range_s ? rd0_addr : 6'd0;
        rd1_idx_s = rd1_in_range_s ? rd1_addr : 6'd0;
        rd0_word_s = select_word(rd0_in_range_s,
                                 wr_en && wr_in_range_s && (wr_addr == rd0_addr),
                                 wr_data, mem_r[rd0_idx_s]);
        rd1_word_s = select_word(rd1_in_range_s,
                                 wr_en && wr_in_range_s && (wr_addr == rd1_addr),
                                 wr_data, mem_r[rd1_idx_s]);
        err_set_s = (wr_en  && !wr_in_range_s)  ||
                    (rd0_en && !rd0_in_range_s) ||
                    (rd1_en && !rd1_in_range_s);
    end

    // Storage array: cleared on reset, written only for in-range addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 40; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en && wr_in_range_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port 0 output register: data updates only on a request, valid follows the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd0_data_r  <= {WIDTH{1'b0}};
            rd0_valid_r <= 1'b0;
        end else begin
            rd0_valid_r <= rd0_en;
            if (rd0_en) begin
                rd0_data_r <= rd0_word_s;
            end
        end
    end

    // Read port 1 output register: data updates only on a request, valid follows the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_data_r  <= {WIDTH{1'b0}};
            rd1_valid_r <= 1'b0;
        end else begin
            rd1_valid_r <= rd1_en;
            if (rd1_en) begin
                rd1_data_r <= rd1_word_s;
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_r <= 1'b0;
        end else if (err_set_s) begin
            addr_err_r <= 1'b1;
        end
    end

    assign rd0_data  = rd0_data_r;
    assign rd0_valid = rd0_valid_r;
    assign rd1_data  = rd1_data_r;
    assign rd1_valid = rd1_valid_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_reg_40xx_2r_1w_sync.sv
// Self-checking bench for reg_40xx_2r_1w_sync: a behavioural model of the
// register file checked against the DUT every cycle, plus directed literal checks.
module tb_reg_40xx_2r_1w_sync;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         rd0_en;
    logic [5:0]   rd0_addr;
    logic         rd1_en;
    logic [5:0]   rd1_addr;
    logic [W-1:0] rd0_data;
    logic         rd0_valid;
    logic [W-1:0] rd1_data;
    logic         rd1_valid;
    logic         addr_err;

    int checks = 0;
    int errors = 0;

    reg_40xx_2r_1w_sync #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd0_en    (rd0_en),
        .rd0_addr  (rd0_addr),
        .rd1_en    (rd1_en),
        .rd1_addr  (rd1_addr),
        .rd0_data  (rd0_data),
        .rd0_valid (rd0_valid),
        .rd1_data  (rd1_data),
        .rd1_valid (rd1_valid),
        .addr_err  (addr_err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_mem [40];
    logic [W-1:0] m_d0, m_d1;
    logic         m_v0, m_v1, m_err;

    function automatic logic [W-1:0] model_read(input logic [5:0] a);
        if (a >= 6'd40) return '0;
        if (wr_en && (wr_addr == a)) return wr_data;
        return m_mem[a];
    endfunction

    // Model state update: what the spec says each edge must do.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 40; i++) m_mem[i] <= '0;
            m_d0 <= '0; m_d1 <= '0; m_v0 <= 1'b0; m_v1 <= 1'b0; m_err <= 1'b0;
        end else begin
            m_v0 <= rd0_en;
            m_v1 <= rd1_en;
            if (rd0_en) m_d0 <= model_read(rd0_addr);
            if (rd1_en) m_d1 <= model_read(rd1_addr);
            if (wr_en && wr_addr < 6'd40) m_mem[wr_addr] <= wr_data;
            if ((wr_en && wr_addr >= 6'd40) || (rd0_en && rd0_addr >= 6'd40) ||
                (rd1_en && rd1_addr >= 6'd40)) m_err <= 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("model_rd0_valid", {63'd0, rd0_valid}, {63'd0, m_v0});
            check("model_rd1_valid", {63'd0, rd1_valid}, {63'd0, m_v1});
            check("model_rd0_data", rd0_data, m_d0);
            check("model_rd1_data", rd1_data, m_d1);
            check("model_addr_err", {63'd0, addr_err}, {63'd0, m_err});
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 6'd0; wr_data = '0;
        rd0_en = 1'b0; rd0_addr = 6'd0; rd1_en = 1'b0; rd1_addr = 6'd0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rd0_valid", {63'd0, rd0_valid}, 64'd0);
        check("reset_rd0_data", rd0_data, 64'd0);
        check("reset_addr_err", {63'd0, addr_err}, 64'd0);
        rst = 1'b1;

        // Unwritten entries 0 and 39 read zero on both ports.
        rd0_en = 1'b1; rd0_addr = 6'd0; rd1_en = 1'b1; rd1_addr = 6'd39;
        @(negedge clk);
        check("unwritten_rd0", rd0_data, 64'd0);
        check("unwritten_rd1_valid", {63'd0, rd1_valid}, 64'd1);
        rd0_addr = 6'd39; rd1_addr = 6'd0;
        @(negedge clk);
        check("unwritten_err", {63'd0, addr_err}, 64'd0);

        // Write entry 5, read it back next cycle.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        check("wr5_no_valid", {63'd0, rd0_valid}, 64'd0);
        idle_inputs();
        rd0_en = 1'b1; rd0_addr = 6'd5;
        @(negedge clk);
        check("rd5_data", rd0_data, 64'hDEAD_BEEF_0000_0001);

        // Same-edge write and dual read of entry 17: bypass.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 6'd17; wr_data = 64'h1234;
        rd0_en = 1'b1; rd0_addr = 6'd17; rd1_en = 1'b1; rd1_addr = 6'd17;
        @(negedge clk);
        check("bypass_rd0", rd0_data, 64'h1234);
        check("bypass_rd1", rd1_data, 64'h1234);

        // Read 0xAA then drop rd0_en: valid falls, data holds.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 64'hAA;
        @(negedge clk);
        idle_inputs();
        rd0_en = 1'b1; rd0_addr = 6'd3;
        @(negedge clk);
        check("aa_read", rd0_data, 64'hAA);
        idle_inputs();
        @(negedge clk);
        check("aa_valid_low", {63'd0, rd0_valid}, 64'd0);
        check("aa_hold", rd0_data, 64'hAA);

        // Out-of-range write then out-of-range read: sticky error, zero data.
        wr_en = 1'b1; wr_addr = 6'd40; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("oor_wr_err", {63'd0, addr_err}, 64'd1);
        idle_inputs();
        rd0_en = 1'b1; rd0_addr = 6'd63;
        @(negedge clk);
        check("oor_rd_data", rd0_data, 64'd0);
        check("oor_rd_valid", {63'd0, rd0_valid}, 64'd1);
        idle_inputs();
        rd1_en = 1'b1; rd1_addr = 6'd5;
        @(negedge clk);
        @(negedge clk);
        check("oor_sticky", {63'd0, addr_err}, 64'd1);
        check("oor_entry5_kept", rd1_data, 64'hDEAD_BEEF_0000_0001);

        // Fill all entries with their index.
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 64'(i);
            @(negedge clk);
        end
        idle_inputs();

        // Read stream with reset asserted part way through.
        for (int i = 0; i < 40; i++) begin
            rd0_en = 1'b1; rd0_addr = 6'(i); rd1_en = 1'b1; rd1_addr = 6'(39 - i);
            if (i == 20) begin
                #1 rst = 1'b0;
                #1;
                check("async_rst_rd0_valid", {63'd0, rd0_valid}, 64'd0);
                check("async_rst_rd0_data", rd0_data, 64'd0);
                check("async_rst_addr_err", {63'd0, addr_err}, 64'd0);
                @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                check("post_rst_rd0_valid", {63'd0, rd0_valid}, 64'd0);
                check("post_rst_rd1_valid", {63'd0, rd1_valid}, 64'd0);
                break;
            end
            @(negedge clk);
            if (i == 10) check("fill_rd0_10", rd0_data, 64'd10);
        end

        // Every entry reads zero after the reset.
        for (int i = 0; i < 40; i++) begin
            rd0_en = 1'b1; rd0_addr = 6'(i); rd1_en = 1'b1; rd1_addr = 6'(39 - i);
            @(negedge clk);
            check("post_rst_rd0_zero", rd0_data, 64'd0);
            check("post_rst_rd1_zero", rd1_data, 64'd0);
        end
        idle_inputs();
        @(negedge clk);
        check("final_addr_err", {63'd0, addr_err}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_40xx_2r_1w_sync.md
REG_40XX_2R_1W_SYNC -- requirements
Module: reg_40xX_2r_1w_sync

Interface
REQ-001: Parameter WIDTH, default 64, sets the data width of every entry and every data port.
REQ-002: Port clk, input, 1 bit, is the single clock; all state SHALL update on the rising edge.
REQ-003: Port rst, input, 1 bit, is the asynchronous active-low reset.
REQ-004: Port wr_en, input, 1 bit, is the write request.
REQ-005: Port wr_addr, input, 6 bits, is the write entry index.
REQ-006: Port wr_data, input, WIDTH bits, is the write data.
REQ-007: Ports rd0_en and rd1_en, input, 1 bit each, are the read requests for ports 0 and 1.
REQ-008: Ports rd0_addr and rd1_addr, input, 6 bits each, are the read entry indices.
REQ-009: Ports rd0_data and rd1_data, output, WIDTH bits each, are the registered read data.
REQ-010: Ports rd0_valid and rd1_valid, output, 1 bit each, are the read-data-valid strobes.
REQ-011: Port addr_err, output, 1 bit, is a sticky flag indicating an out-of-range access.

Function
REQ-012: Storage SHALL be 40 entries of WIDTH bits, indexed 0..39.
REQ-013: Write: wr_en=1 with wr_addr<40 SHALL store wr_data into entry wr_addr at the clock edge.
REQ-014: Write with wr_addr>=40 SHALL leave all entries unchanged and SHALL set addr_err.
REQ-015: Read: rdN_en=1 at edge k SHALL drive rdN_data with entry rdN_addr and rdN_valid=1 after edge k, which is one-cycle latency.
REQ-016: rdN_en=0 at edge k SHALL drive rdN_valid=0 after edge k; rdN_data SHALL hold its previous value.
REQ-017: Read with rdN_addr>=40 SHALL return all-zero data with rdN_valid=1 and SHALL set addr_err.
REQ-018: Write-first bypass: a read and a valid write to the same entry at the same edge SHALL return wr_data, not the old contents.
REQ-019: Both read ports SHALL operate independently; reads of the same address on both ports at the same edge SHALL return identical data.
REQ-020: addr_err SHALL remain 1 after it is set, until reset.
REQ-021: The block SHALL have no backpressure; every request SHALL be accepted in the cycle it is presented.
REQ-022: Outputs SHALL never be X after reset; no X-assignment SHALL be used for any data path.

Reset
REQ-023: Asserting rst low SHALL immediately clear all 40 entries, rd0_data, rd1_data, rd0_valid, rd1_valid and addr_err to 0, without waiting for a clock edge.
REQ-024: Reset asserted during active reads or writes SHALL discard in-flight results; no rdN_valid SHALL appear for requests made before reset.
REQ-025: After deassertion, the first edge with rdN_en=1 SHALL return 0 for any unwritten entry.

Verification
REQ-026: Reset, then read entries 0 and 39 on both ports -> rd0_data=rd1_data=0 and rdN_valid=1 one cycle later; addr_err=0.
REQ-027: Write 0xDEAD_BEEF_0000_0001 to entry 5, then read entry 5 on port 0 in the next cycle -> rd0_data=0xDEAD_BEEF_0000_0001 one cycle later.
REQ-028: Same-edge write 0x1234 to entry 17 and read of entry 17 on both ports -> both ports return 0x1234.
REQ-029: Write to address 40, then read address 63 -> entries unchanged, read returns 0 with valid=1, addr_err=1 and sticky.
REQ-030: Fill all 40 entries with their index, assert rst mid-stream for a half cycle, then read all entries -> every read returns 0, and no valid appears for the pre-reset reads.
REQ-031: Toggle rd0_en off after a read of 0xAA -> rd0_valid=0 and rd0_data holds 0xAA.
